capture_rle_expand: RTL and testbench

- Read-side consumer of the capture RLE word stream.
- Pops 32-bit RLE words from the capture CDC FIFO read port (show-ahead data, pop/empty handshake).
- Expands each word into one output sample per cycle on a valid/accept stream, feeding the host-side sample path (USB/trigger formatter).
- Single clock domain: the FIFO read clock.

---
 rtl/capture_rle_expand.sv | 111 +++++++++++
 tb/tb_capture_rle_expand.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_rle_expand.sv
// Capture RLE word expander: pops run-length words from the capture FIFO
// and emits one sample per cycle. Optional stats: CAPTURE_RLE_EXPAND_STATS_EN.
module capture_rle_expand #(
    parameter int SAMPLE_W = 16,
    parameter int COUNT_W  = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [31:0]         in_data_i,
    input  logic                in_empty_i,
    output logic                in_pop_o,
    output logic                out_valid_o,
    output logic [SAMPLE_W-1:0] out_data_o,
    input  logic                out_accept_i,
    output logic                busy_o,
    output logic [15:0]         drop_count_o,
    output logic [31:0]         sample_count_o
);

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SAMPLE_W-1:0] r_word;
    logic [COUNT_W-1:0]  r_remain;
    logic [15:0]         r_drop;

    logic w_valid;
    logic w_last;
    logic w_load;
    logic w_run;
    logic w_step;

    assign w_valid = (r_state == S_EXPAND);
    assign w_last  = (r_remain == '0);
    assign w_run   = in_data_i[31];
    // A new word may enter when idle, or when the final sample of the
    // current run is being accepted this very cycle (no bubble).
    assign w_load  = ~rst_i & enable_i & ~in_empty_i
                   & (~w_valid | (out_accept_i & w_last));
    assign w_step  = w_valid & out_accept_i & ~w_last;

    assign in_pop_o     = w_load;
    assign out_valid_o  = w_valid;
    assign out_data_o   = r_word;
    assign busy_o       = w_valid;
    assign drop_count_o = r_drop;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a popped run word starts EXPAND; a marker or finished run idles.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_run ? S_EXPAND : S_IDLE;
        end else if (w_valid && out_accept_i && w_last) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Run value and remaining-sample counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word   <= '0;
            r_remain <= '0;
        end else if (w_load && w_run) begin
            r_word   <= in_data_i[SAMPLE_W-1:0];
            r_remain <= in_data_i[SAMPLE_W+COUNT_W-1:SAMPLE_W];
        end else if (w_step) begin
            r_remain <= r_remain - COUNT_W'(1);
        end
    end

    // Saturating count of discarded marker words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop <= '0;
        end else if (w_load && !w_run && r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
        end
    end

`ifdef CAPTURE_RLE_EXPAND_STATS_EN
    logic [31:0] r_samples;

    // Saturating count of samples handed downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_samples <= '0;
        end else if (w_valid && out_accept_i && r_samples != 32'hFFFF_FFFF) begin
            r_samples <= r_samples + 32'd1;
        end
    end

    assign sample_count_o = r_samples;
`else
    assign sample_count_o = '0;
`endif

endmodule

// File: tb/tb_capture_rle_expand.sv
// Directed bench for capture_rle_expand with a queue-modelled FIFO.
// Sample-count checks follow CAPTURE_RLE_EXPAND_STATS_EN.
module tb_capture_rle_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] in_data;
    logic        in_empty;
    logic        in_pop;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_accept;
    logic        busy;
    logic [15:0] drop_count;
    logic [31:0] sample_count;

    always #5 clk = ~clk;

    capture_rle_expand dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .in_data_i      (in_data),
        .in_empty_i     (in_empty),
        .in_pop_o       (in_pop),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_accept_i   (out_accept),
        .busy_o         (busy),
        .drop_count_o   (drop_count),
        .sample_count_o (sample_count)
    );

    logic [31:0] fifo[$];
    int          checks = 0;
    int          errors = 0;
    int          n_pop  = 0;
    logic [31:0] exp_sc = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sc_exp();
`ifdef CAPTURE_RLE_EXPAND_STATS_EN
        return exp_sc;
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive();
        in_empty = (fifo.size() == 0);
        in_data  = in_empty ? 32'd0 : fifo[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        drive();
        #1;
    endtask

    // One clock: note pre-edge pop/accept, advance, update FIFO model.
    task automatic tick();
        logic p;
        logic a;
        p = in_pop;
        a = out_valid & out_accept;
        @(posedge clk);
        #1;
        if (p) begin
            if (fifo.size() == 0) begin
                chk("pop_on_empty", 32'd1, 32'd0);
            end else begin
                fifo.delete(0);
            end
            n_pop++;
        end
        if (rst) exp_sc = '0;
        else if (a && exp_sc != 32'hFFFF_FFFF) exp_sc++;
        drive();
        #1;
    endtask

    initial begin
        int n;
        int guard;
        int p0;

        rst        = 1'b1;
        enable     = 1'b0;
        out_accept = 1'b0;
        drive();
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_pop",   32'(in_pop),    32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_drop",  32'(drop_count), 32'd0);
        chk("rst_sc",    sample_count,   32'd0);
        rst = 1'b0;
        #1;

        // Single word, three samples.
        enable     = 1'b1;
        out_accept = 1'b1;
        push(32'h8002_00AB);
        chk("t1_pop0", 32'(in_pop), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_data",  32'(out_data),  32'h00AB);
            chk("t1_busy",  32'(busy),      32'd1);
        end
        tick();
        chk("t1_idle", 32'(out_valid), 32'd0);
        chk("t1_sc",   sample_count,   sc_exp());
        chk("t1_sc3",  32'(sc_exp() == 32'd0 || sc_exp() == 32'd3), 32'd1);

        // Back-to-back words.
        push(32'h8000_1111);
        push(32'h8001_2222);
        chk("t2_pop0", 32'(in_pop), 32'd1);
        tick();
        chk("t2_d0",   32'(out_data), 32'h1111);
        chk("t2_pop1", 32'(in_pop),   32'd1);
        tick();
        chk("t2_v1",   32'(out_valid), 32'd1);
        chk("t2_d1",   32'(out_data),  32'h2222);
        chk("t2_pop2", 32'(in_pop),    32'd0);
        tick();
        chk("t2_v2",   32'(out_valid), 32'd1);
        chk("t2_d2",   32'(out_data),  32'h2222);
        tick();
        chk("t2_idle", 32'(out_valid), 32'd0);

        // Backpressure hold.
        push(32'h8003_0055);
        push(32'h8000_0099);
        tick();
        out_accept = 1'b0;
        #1;
        chk("t3_pop_hold", 32'(in_pop), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hv", 32'(out_valid), 32'd1);
            chk("t3_hd", 32'(out_data),  32'h0055);
            chk("t3_hp", 32'(in_pop),    32'd0);
        end
        out_accept = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_v", 32'(out_valid), 32'd1);
            chk("t3_d", 32'(out_data),  32'h0055);
            chk("t3_p", 32'(in_pop),    (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t3_next", 32'(out_data),  32'h0099);
        chk("t3_nv",   32'(out_valid), 32'd1);
        tick();
        chk("t3_idle", 32'(out_valid), 32'd0);

        // Marker word dropped.
        push(32'h0000_0000);
        push(32'h8000_0077);
        chk("t4_pop0", 32'(in_pop), 32'd1);
        tick();
        chk("t4_v0",   32'(out_valid),  32'd0);
        chk("t4_drop", 32'(drop_count), 32'd1);
        chk("t4_pop1", 32'(in_pop),     32'd1);
        tick();
        chk("t4_v1",   32'(out_valid), 32'd1);
        chk("t4_d1",   32'(out_data),  32'h0077);
        tick();
        chk("t4_idle", 32'(out_valid), 32'd0);

        // Maximum run, enable dropped mid-run.
        push(32'hFFFF_1234);
        push(32'h8000_0001);
        tick();
        enable = 1'b0;
        #1;
        p0    = n_pop;
        n     = 0;
        guard = 0;
        while (out_valid && guard < 40000) begin
            if (out_data == 16'h1234) n++;
            tick();
            guard++;
        end
        chk("t5_count", 32'(n), 32'd32768);
        chk("t5_pops",  32'(n_pop - p0), 32'd0);
        chk("t5_idle",  32'(out_valid), 32'd0);
        tick();
        tick();
        chk("t5_nopop", 32'(in_pop), 32'd0);
        chk("t5_sc",    sample_count, sc_exp());
        enable = 1'b1;
        #1;
        chk("t5_repop", 32'(in_pop), 32'd1);
        tick();
        chk("t5_d", 32'(out_data), 32'h0001);
        tick();
        chk("t5_end", 32'(out_valid), 32'd0);

        // Reset mid-run.
        push(32'h8014_00CC);
        tick();
        repeat (10) tick();
        push(32'h8000_00DD);
        chk("t6_run", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_pop_rst", 32'(in_pop), 32'd0);
        tick();
        chk("t6_valid", 32'(out_valid),  32'd0);
        chk("t6_pop",   32'(in_pop),     32'd0);
        chk("t6_drop",  32'(drop_count), 32'd0);
        chk("t6_sc",    sample_count,    32'd0);
        rst = 1'b0;
        #1;
        chk("t6_repop", 32'(in_pop), 32'd1);
        tick();
        chk("t6_v", 32'(out_valid), 32'd1);
        chk("t6_d", 32'(out_data),  32'h00DD);
        tick();
        chk("t6_idle", 32'(out_valid), 32'd0);
        chk("t6_sc1",  sample_count,    sc_exp());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
